mem_wb_stage: RTL and testbench

MEM/WB pipeline register and write-back formatter for the 5-stage MIPS core. Captures the memory-stage result each cycle, extracts and extends load data (byte/half/word), selects ALU result or load data, and drives the register file write port (WE, rW, W) directly. Also flags misaligned loads and counts retired instructions.

---
 rtl/mem_wb_stage.sv | 147 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and write-back formatter.
// Extracts byte/half/word load data, selects the ALU result or the load
// data, and drives the register-file write port straight from registers.
// Also flags misaligned loads and, optionally, counts retired instructions.
// Optional feature macro: MEM_WB_INSTRET_EN (builds the instret counter;
// when undefined, instret is tied to 0).
// The byte and half lane selection assumes DW is at least 32.
module mem_wb_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          m_valid,
    input  logic          m_regwrite,
    input  logic          m_memtoreg,
    input  logic [2:0]    m_ldtype,
    input  logic [AW-1:0] m_rd,
    input  logic [DW-1:0] m_alu,
    input  logic [DW-1:0] m_rdata,
    output logic          WE,
    output logic [AW-1:0] rW,
    output logic [DW-1:0] W,
    output logic          wb_valid,
    output logic          misalign,
    output logic [31:0]   instret
);

    // Load types. Encodings 101-111 are not listed and fall back to LW.
    typedef enum logic [2:0] {
        LD_LW  = 3'b000,
        LD_LB  = 3'b001,
        LD_LBU = 3'b010,
        LD_LH  = 3'b011,
        LD_LHU = 3'b100
    } ld_type_e;

    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [DW-1:0] w_load_data;
    logic          w_misalign;
    logic [DW-1:0] w_wdata;
    logic          w_we;
    logic          w_retire;

    logic          r_valid;
    logic          r_we;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_w;
    logic          r_misalign;

    // Pick the addressed little-endian byte and half-word out of the memory word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        w_byte = m_rdata[7:0];
        case (m_alu[1:0])
            2'd1:    w_byte = m_rdata[15:8];
            2'd2:    w_byte = m_rdata[23:16];
            2'd3:    w_byte = m_rdata[31:24];
            default: w_byte = m_rdata[7:0];
        endcase
        w_half = m_alu[1] ? m_rdata[31:16] : m_rdata[15:0];
    end

    // Extend the selected lane per load type and detect misalignment.
    always_comb begin
        w_load_data = m_rdata;
        w_misalign  = 1'b0;
        case (m_ldtype)
            LD_LB:  w_load_data = {{(DW-8){w_byte[7]}}, w_byte};
            LD_LBU: w_load_data = {{(DW-8){1'b0}}, w_byte};
            LD_LH: begin
                w_load_data = {{(DW-16){w_half[15]}}, w_half};
                w_misalign  = m_alu[0];
            end
            LD_LHU: begin
                w_load_data = {{(DW-16){1'b0}}, w_half};
                w_misalign  = m_alu[0];
            end
            default: begin
                w_load_data = m_rdata;
                w_misalign  = (m_alu[1:0] != 2'b00);
            end
        endcase
        // A non-load instruction never checks alignment.
        if (!m_memtoreg) begin
            w_misalign = 1'b0;
        end
    end

    assign w_wdata  = m_memtoreg ? w_load_data : m_alu;
    assign w_we     = m_valid & m_regwrite & (m_rd != '0) & ~w_misalign;
    assign w_retire = m_valid & ~w_misalign;

    // WB pipeline register: reset > flush > stall > capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_rd       <= '0;
            r_w        <= '0;
            r_misalign <= 1'b0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_rd       <= '0;
            r_w        <= '0;
            r_misalign <= 1'b0;
        end else if (!stall) begin
            r_valid    <= m_valid;
            r_we       <= w_we;
            r_rd       <= m_rd;
            r_w        <= w_wdata;
            r_misalign <= w_misalign;
        end
    end

`ifdef MEM_WB_INSTRET_EN
    logic [31:0] r_instret;

    // Retired-instruction counter, advancing only on edges that capture a retiring entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (!flush && !stall && w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;
`else
    // Counter not built; w_retire is left without a load.
    assign instret = '0;
    logic w_unused_retire;
    assign w_unused_retire = w_retire;
`endif

    assign WE       = r_we;
    assign rW       = r_rd;
    assign W        = r_w;
    assign wb_valid = r_valid;
    assign misalign = r_misalign;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed steps from the test plan,
// then randomized traffic, all compared against a behavioural model.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n, stall, flush;
    logic          m_valid, m_regwrite, m_memtoreg;
    logic [2:0]    m_ldtype;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_alu, m_rdata;
    logic          WE, wb_valid, misalign;
    logic [AW-1:0] rW;
    logic [DW-1:0] W;
    logic [31:0]   instret;

    int n_pass  = 0;
    int n_total = 0;

    // Model state.
    logic        e_valid, e_we, e_mis;
    logic [4:0]  e_rd;
    logic [31:0] e_w;
    logic [31:0] e_cnt;

    mem_wb_stage #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_regwrite(m_regwrite), .m_memtoreg(m_memtoreg),
        .m_ldtype(m_ldtype), .m_rd(m_rd), .m_alu(m_alu), .m_rdata(m_rdata),
        .WE(WE), .rW(rW), .W(W), .wb_valid(wb_valid), .misalign(misalign),
        .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference behaviour of one clock edge, evaluated from the listed rules.
    task automatic model_edge();
        logic        word_class, is_load, mis;
        logic [31:0] lane_val, data;
        if (!rst_n) begin
            {e_valid, e_we, e_mis, e_rd, e_w, e_cnt} = '0;
        end else if (flush) begin
            {e_valid, e_we, e_mis, e_rd, e_w} = '0;
        end else if (!stall) begin
            word_class = (m_ldtype == 3'd0) || (m_ldtype > 3'd4);
            is_load    = m_memtoreg;
            mis = is_load && ((word_class && (m_alu % 4 != 0)) ||
                              ((m_ldtype == 3'd3 || m_ldtype == 3'd4) && (m_alu % 2 != 0)));
            data = m_rdata;
            if (m_ldtype == 3'd1 || m_ldtype == 3'd2) begin
                lane_val = (m_rdata >> (8 * (m_alu % 4))) & 32'hFF;
                if (m_ldtype == 3'd1 && lane_val >= 128) lane_val = lane_val - 256;
                data = lane_val;
            end else if (m_ldtype == 3'd3 || m_ldtype == 3'd4) begin
                lane_val = (m_rdata >> (16 * ((m_alu / 2) % 2))) & 32'hFFFF;
                if (m_ldtype == 3'd3 && lane_val >= 32768) lane_val = lane_val - 65536;
                data = lane_val;
            end
            e_valid = m_valid;
            e_rd    = m_rd;
            e_w     = is_load ? data : m_alu;
            e_mis   = mis;
            e_we    = m_valid && m_regwrite && (m_rd != 0) && !mis;
            if (m_valid && !mis) e_cnt = e_cnt + 1;
        end
    endtask

    function automatic logic [31:0] exp_instret();
`ifdef MEM_WB_INSTRET_EN
        return e_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".WE"},       {31'd0, WE},       {31'd0, e_we});
        check({tag, ".rW"},       {27'd0, rW},       {27'd0, e_rd});
        check({tag, ".W"},        W,                 e_w);
        check({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, e_valid});
        check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
        check({tag, ".instret"},  instret,           exp_instret());
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic rw, input logic mtr, input logic [2:0] lt,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata);
        m_valid = v; m_regwrite = rw; m_memtoreg = mtr; m_ldtype = lt;
        m_rd = rd; m_alu = alu; m_rdata = rdata;
    endtask

    logic [31:0] held_w;
    logic [31:0] held_cnt;

    initial begin
        {e_valid, e_we, e_mis, e_rd, e_w, e_cnt} = '0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1, 1, 0, 3'd0, 5'd7, 32'hDEAD_BEEF, 32'h0);

        // Reset with a valid writing instruction on the inputs.
        step("reset");
        check("reset.W_const", W, 32'h0);

        // ALU write.
        rst_n = 1'b1;
        drive(1, 1, 0, 3'd0, 5'd5, 32'h1234_5678, 32'h0);
        step("alu");
        check("alu.W_const", W, 32'h1234_5678);

        // Load extraction from a fixed memory word.
        drive(1, 1, 1, 3'd1, 5'd9, 32'h0000_2003, 32'h80FF_7F01);
        step("lb3");
        check("lb3.W_const", W, 32'hFFFF_FF80);
        drive(1, 1, 1, 3'd2, 5'd9, 32'h0000_2001, 32'h80FF_7F01);
        step("lbu1");
        check("lbu1.W_const", W, 32'h0000_007F);
        drive(1, 1, 1, 3'd3, 5'd9, 32'h0000_2002, 32'h80FF_7F01);
        step("lh2");
        check("lh2.W_const", W, 32'hFFFF_80FF);
        drive(1, 1, 1, 3'd4, 5'd9, 32'h0000_2000, 32'h80FF_7F01);
        step("lhu0");
        check("lhu0.W_const", W, 32'h0000_7F01);
        drive(1, 1, 1, 3'd6, 5'd9, 32'h0000_2004, 32'h80FF_7F01);
        step("lw_alias");

        // Misaligned loads.
        held_cnt = instret;
        drive(1, 1, 1, 3'd0, 5'd8, 32'h0000_1002, 32'h80FF_7F01);
        step("mis_lw");
        check("mis_lw.WE_const", {31'd0, WE}, 32'd0);
        check("mis_lw.instret_hold", instret, held_cnt);
        drive(1, 1, 1, 3'd3, 5'd8, 32'h0000_1001, 32'h80FF_7F01);
        step("mis_lh");
        // An odd address is fine for a non-load.
        drive(1, 1, 0, 3'd0, 5'd8, 32'h0000_1001, 32'h80FF_7F01);
        step("alu_odd");

        // Write to r0 is suppressed but the instruction still retires.
        drive(1, 1, 0, 3'd0, 5'd0, 32'h0000_00AA, 32'h0);
        step("rd0");

        // Stall for three cycles with different inputs on the MEM side.
        drive(1, 1, 0, 3'd0, 5'd12, 32'hCAFE_0001, 32'h0);
        step("pre_stall");
        held_w = W;
        stall = 1'b1;
        drive(1, 1, 0, 3'd0, 5'd13, 32'h5555_AAAA, 32'h0);
        for (int i = 0; i < 3; i++) step("stall");
        check("stall.W_hold", W, held_w);

        // Stall and flush together: flush wins.
        flush = 1'b1;
        step("stall_flush");
        flush = 1'b0; stall = 1'b0;
        drive(1, 1, 1, 3'd2, 5'd3, 32'h0000_0002, 32'h1122_3344);
        step("post_flush");

        // Reset while stalled.
        stall = 1'b1; rst_n = 1'b0;
        step("rst_in_stall");
        rst_n = 1'b1; stall = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 99) >= 2);
            stall = ($urandom_range(0, 99) < 15);
            flush = ($urandom_range(0, 99) < 8);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
